// File: rtl/mem_dump_uart.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dump_uart
//  Description : On a processor-halt rising edge, reads N_WORDS data-RAM words
//                and streams them byte by byte to a UART TX (start/done).
//                Optional macro MEM_DUMP_CSUM_EN appends an XOR checksum byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_dump_uart #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 11,
    parameter int N_WORDS   = 16,
    parameter int BASE_ADDR = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_halt,
    output logic              o_rd,
    output logic [ADDR_W-1:0] o_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    input  logic              i_tx_done,
    output logic              o_busy,
    output logic              o_done
);

    localparam int c_bytes  = DATA_W / 8;
    localparam int c_wcnt_w = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int c_bcnt_w = (c_bytes > 1) ? $clog2(c_bytes) : 1;
    localparam logic [c_wcnt_w-1:0] c_last_word = c_wcnt_w'(N_WORDS - 1);
    localparam logic [c_bcnt_w-1:0] c_last_byte = c_bcnt_w'(c_bytes - 1);
    localparam logic [ADDR_W-1:0]   c_base      = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_SEND  = 3'd3,
        S_WAIT  = 3'd4,
`ifdef MEM_DUMP_CSUM_EN
        S_CSUM  = 3'd6,
        S_CWAIT = 3'd7,
`endif
        S_DONE  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  halt_q, halt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [c_wcnt_w-1:0]   word_cnt_q, word_cnt_d;
    logic [c_bcnt_w-1:0]   byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
`ifdef MEM_DUMP_CSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic       w_trigger;
    logic [7:0] w_cur_byte;

    assign w_trigger  = i_halt & ~halt_q;
    assign w_cur_byte = (MSB_FIRST != 0) ? shift_q[DATA_W-1 -: 8] : shift_q[7:0];
    assign o_addr     = addr_q;
    assign o_busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_done     = (state_q == S_DONE);

    always_comb begin
        state_d    = state_q;
        halt_d     = i_halt;
        addr_d     = addr_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
`ifdef MEM_DUMP_CSUM_EN
        csum_d     = csum_q;
`endif
        o_rd       = 1'b0;
        o_tx_start = 1'b0;
        o_tx_data  = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (w_trigger) begin
                    state_d    = S_READ;
                    word_cnt_d = '0;
                    addr_d     = c_base;
`ifdef MEM_DUMP_CSUM_EN
                    csum_d     = 8'h00;
`endif
                end
            end
            S_READ: begin
                o_rd    = 1'b1;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                o_rd       = 1'b1;
                shift_d    = i_data;
                byte_cnt_d = '0;
                state_d    = S_SEND;
            end
            S_SEND: begin
                o_tx_start = 1'b1;
                o_tx_data  = w_cur_byte;
`ifdef MEM_DUMP_CSUM_EN
                csum_d     = csum_q ^ w_cur_byte;
`endif
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                o_tx_data = w_cur_byte;
                if (i_tx_done) begin
                    if (byte_cnt_q != c_last_byte) begin
                        shift_d    = (MSB_FIRST != 0) ? (shift_q << 8) : (shift_q >> 8);
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = S_SEND;
                    end else if (word_cnt_q != c_last_word) begin
                        addr_d     = addr_q + 1'b1;
                        word_cnt_d = word_cnt_q + 1'b1;
                        state_d    = S_READ;
                    end else begin
`ifdef MEM_DUMP_CSUM_EN
                        state_d    = S_CSUM;
`else
                        state_d    = S_DONE;
`endif
                    end
                end
            end
`ifdef MEM_DUMP_CSUM_EN
            S_CSUM: begin
                o_tx_start = 1'b1;
                o_tx_data  = csum_q;
                state_d    = S_CWAIT;
            end
            S_CWAIT: begin
                o_tx_data = csum_q;
                if (i_tx_done) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (!i_halt) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // halt_q resets high so a halt already asserted at reset release is not an edge
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            halt_q     <= 1'b1;
            addr_q     <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
`ifdef MEM_DUMP_CSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            halt_q     <= halt_d;
            addr_q     <= addr_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
`ifdef MEM_DUMP_CSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_dump_uart.sv
`default_nettype none
// Testbench for mem_dump_uart: four parameterisations, scoreboard of expected
// bytes/addresses checked as the DUTs emit them.
module tb_mem_dump_uart;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_bytes[$];
    logic [10:0] exp_addrs[$];

    logic [3:0] halt = 4'b0;
    logic [3:0] fdone = 4'b0;
    logic [3:0] mdone;
    logic [3:0] start;
    int         cnt[4];

    logic        rd0, busy0, dn0; logic [10:0] addr0; logic [15:0] data0; logic [7:0] txd0;
    logic        rd1, busy1, dn1; logic [10:0] addr1; logic [31:0] data1; logic [7:0] txd1;
    logic        rd2, busy2, dn2; logic [10:0] addr2; logic [15:0] data2; logic [7:0] txd2;
    logic        rd3, busy3, dn3; logic [10:0] addr3; logic [15:0] data3; logic [7:0] txd3;

    mem_dump_uart u0 (
        .i_clock(clk), .i_reset(rst_n), .i_halt(halt[0]), .o_rd(rd0), .o_addr(addr0),
        .i_data(data0), .o_tx_data(txd0), .o_tx_start(start[0]), .i_tx_done(mdone[0] | fdone[0]),
        .o_busy(busy0), .o_done(dn0));
    mem_dump_uart #(.DATA_W(32), .N_WORDS(2), .MSB_FIRST(0)) u1 (
        .i_clock(clk), .i_reset(rst_n), .i_halt(halt[1]), .o_rd(rd1), .o_addr(addr1),
        .i_data(data1), .o_tx_data(txd1), .o_tx_start(start[1]), .i_tx_done(mdone[1] | fdone[1]),
        .o_busy(busy1), .o_done(dn1));
    mem_dump_uart #(.BASE_ADDR(2046), .N_WORDS(4)) u2 (
        .i_clock(clk), .i_reset(rst_n), .i_halt(halt[2]), .o_rd(rd2), .o_addr(addr2),
        .i_data(data2), .o_tx_data(txd2), .o_tx_start(start[2]), .i_tx_done(mdone[2] | fdone[2]),
        .o_busy(busy2), .o_done(dn2));
    mem_dump_uart #(.N_WORDS(1)) u3 (
        .i_clock(clk), .i_reset(rst_n), .i_halt(halt[3]), .o_rd(rd3), .o_addr(addr3),
        .i_data(data3), .o_tx_data(txd3), .o_tx_start(start[3]), .i_tx_done(mdone[3] | fdone[3]),
        .o_busy(busy3), .o_done(dn3));

    // RAM models: data valid the cycle after the address
    always @(posedge clk) begin
        data0 <= 16'hA000 + 16'(addr0);
        data1 <= (addr1 == 11'd0) ? 32'h11223344 : (addr1 == 11'd1) ? 32'h55667788 : 32'hDEADBEEF;
        data2 <= {5'b0, addr2};
        data3 <= (addr3 == 11'd0) ? 16'h12F0 : 16'hFFFF;
    end

    // UART models: done pulse 20 cycles after each start
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            mdone[i] <= 1'b0;
            if (start[i]) cnt[i] <= 20;
            else if (cnt[i] != 0) begin
                cnt[i] <= cnt[i] - 1;
                if (cnt[i] == 1) mdone[i] <= 1'b1;
            end
        end
    end

    initial begin
        mdone = 4'b0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
    end

    task automatic test_reset();
        logic seen;
        rst_n = 1'b0;
        for (int c = 0; c < 8; c++) begin
            halt  = 4'($urandom_range(0, 15));
            fdone = 4'($urandom_range(0, 15));
            @(negedge clk);
            checks++;
            if ({rd0, start[0], busy0, dn0, txd0, addr0, rd1, busy1, dn1, txd1, addr1,
                 rd2, busy2, dn2, addr2, rd3, busy3, dn3, start[3:1]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got rd0=%b start=%b busy0=%b done0=%b txd0=%h addr0=%0d, required all 0",
                         rd0, start, busy0, dn0, txd0, addr0);
            end
        end
        halt = 4'hF; fdone = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rd0 || rd1 || rd2 || rd3 || busy0 || busy1 || busy2 || busy3) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_halt_high: got activity=%b required 0", seen);
        end
        halt = 4'h0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_defaults();
        int k = 0;
        int first = -1;
        logic [7:0] x = 8'h00;
        logic [7:0] e;
        logic bad;
        exp_bytes.delete();
        for (int i = 0; i < 16; i++) begin
            exp_bytes.push_back(8'hA0);
            exp_bytes.push_back(i[7:0]);
            x = x ^ 8'hA0 ^ i[7:0];
        end
`ifdef MEM_DUMP_CSUM_EN
        exp_bytes.push_back(x);
`endif
        halt[0] = 1'b1;
        while (k < 3000 && !dn0) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                checks++;
                if (!(rd0 === 1'b1 && addr0 === 11'd0 && busy0 === 1'b1)) begin
                    errors++;
                    $display("FAIL first_read: got rd=%b addr=%0d busy=%b required 1,0,1", rd0, addr0, busy0);
                end
            end
            if (start[0]) begin
                if (first < 0) begin
                    first = k;
                    checks++;
                    if (k != 3) begin
                        errors++;
                        $display("FAIL first_start_latency: got %0d required 3", k);
                    end
                end
                checks++;
                if (exp_bytes.size() == 0) begin
                    errors++;
                    $display("FAIL defaults_extra_byte: got %h required none", txd0);
                end else begin
                    e = exp_bytes.pop_front();
                    if (txd0 !== e) begin
                        errors++;
                        $display("FAIL defaults_byte: got %h required %h", txd0, e);
                    end
                end
            end
        end
        checks++;
        if (!(dn0 === 1'b1 && busy0 === 1'b0 && exp_bytes.size() == 0)) begin
            errors++;
            $display("FAIL defaults_done: got done=%b busy=%b left=%0d required 1,0,0", dn0, busy0, exp_bytes.size());
        end
        bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (!dn0 || rd0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL done_hold_while_halt: got left_done=%b required 0", bad);
        end
        halt[0] = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dn0 !== 1'b0) begin
            errors++;
            $display("FAIL done_release: got %b required 0", dn0);
        end
    endtask

    task automatic test_byte_order();
        int k = 0;
        logic [7:0] e;
        logic [7:0] x = 8'h00;
        logic [63:0] pat = 64'h4433221188776655;
        exp_bytes.delete();
        for (int i = 7; i >= 0; i--) begin
            exp_bytes.push_back(pat[i*8 +: 8]);
            x = x ^ pat[i*8 +: 8];
        end
`ifdef MEM_DUMP_CSUM_EN
        exp_bytes.push_back(x);
`endif
        halt[1] = 1'b1;
        while (k < 1000 && !dn1) begin
            @(negedge clk);
            k++;
            if (start[1]) begin
                checks++;
                e = (exp_bytes.size() != 0) ? exp_bytes.pop_front() : 8'hxx;
                if (txd1 !== e) begin
                    errors++;
                    $display("FAIL lsb_first_byte: got %h required %h", txd1, e);
                end
            end
        end
        checks++;
        if (!(dn1 === 1'b1 && exp_bytes.size() == 0)) begin
            errors++;
            $display("FAIL lsb_first_done: got done=%b left=%0d required 1,0", dn1, exp_bytes.size());
        end
        halt[1] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_addr_wrap();
        int k = 0;
        logic prev = 1'b0;
        logic [10:0] e;
        exp_addrs = '{11'd2046, 11'd2047, 11'd0, 11'd1};
        halt[2] = 1'b1;
        while (k < 1000 && !dn2) begin
            @(negedge clk);
            k++;
            if (rd2 && !prev) begin
                checks++;
                e = (exp_addrs.size() != 0) ? exp_addrs.pop_front() : 11'hxxx;
                if (addr2 !== e) begin
                    errors++;
                    $display("FAIL addr_wrap: got %0d required %0d", addr2, e);
                end
            end
            prev = rd2;
        end
        checks++;
        if (!(dn2 === 1'b1 && exp_addrs.size() == 0)) begin
            errors++;
            $display("FAIL addr_wrap_done: got done=%b left=%0d required 1,0", dn2, exp_addrs.size());
        end
        halt[2] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_csum();
        int k = 0;
        logic [7:0] e;
        exp_bytes.delete();
        exp_bytes.push_back(8'h12);
        exp_bytes.push_back(8'hF0);
`ifdef MEM_DUMP_CSUM_EN
        exp_bytes.push_back(8'hE2);
`endif
        halt[3] = 1'b1;
        while (k < 500 && !dn3) begin
            @(negedge clk);
            k++;
            if (start[3]) begin
                checks++;
                e = (exp_bytes.size() != 0) ? exp_bytes.pop_front() : 8'hxx;
                if (txd3 !== e) begin
                    errors++;
                    $display("FAIL single_word_byte: got %h required %h", txd3, e);
                end
            end
        end
        checks++;
        if (!(dn3 === 1'b1 && exp_bytes.size() == 0)) begin
            errors++;
            $display("FAIL single_word_done: got done=%b left=%0d required 1,0", dn3, exp_bytes.size());
        end
        halt[3] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mid_dump();
        int k = 0;
        int n = 0;
        int rst_at = -1;
        logic [7:0] e;
        exp_bytes.delete();
        for (int i = 0; i < 16; i++) begin
            exp_bytes.push_back(8'hA0);
            exp_bytes.push_back(i[7:0]);
        end
        halt[0] = 1'b1;
        while (k < 3000) begin
            @(negedge clk);
            k++;
            if (k == 10) halt[0] = 1'b0;
            if (k == 15) halt[0] = 1'b1;
            if (start[0]) begin
                n++;
                checks++;
                e = (exp_bytes.size() != 0) ? exp_bytes.pop_front() : 8'hxx;
                if (txd0 !== e) begin
                    errors++;
                    $display("FAIL mid_dump_byte: got %h required %h", txd0, e);
                end
                if (n == 20) rst_at = k + 5;
            end
            if (k == rst_at) break;
            fdone[0] = rd0;
        end
        fdone[0] = 1'b0;
        checks++;
        if (k != rst_at || busy0 !== 1'b1 || start[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_dump_reached_wait: got cycle=%0d busy=%b required cycle=%0d busy=1", k, busy0, rst_at);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({start[0], busy0, rd0, dn0, txd0} !== '0) begin
            errors++;
            $display("FAIL reset_mid_dump: got start=%b busy=%b rd=%b txd=%h required 0", start[0], busy0, rd0, txd0);
        end
        halt[0] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({start[0], busy0, addr0} !== '0) begin
            errors++;
            $display("FAIL reset_mid_dump_idle: got start=%b busy=%b addr=%0d required 0", start[0], busy0, addr0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_defaults();
        test_byte_order();
        test_addr_wrap();
        test_csum();
        test_mid_dump();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
